// File: rtl/cpu_0_mul_seq_if.sv
// Issue/writeback handshake bundle for the cpu_0 multi-cycle multiply sequencer.
interface cpu_0_mul_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output start_valid, op, src1, src2, result_ready,
    input  start_ready, result_valid, result, busy
  );

  modport slave (
    input  start_valid, op, src1, src2, result_ready,
    output start_ready, result_valid, result, busy
  );
endinterface

// File: rtl/cpu_0_mul_seq.sv
// 32x32 multiply sequencer sharing one registered 16x16 unsigned multiplier over four passes.
// Optional CPU_0_MUL_EARLY_OUT_EN: low-word MUL skips the hi x hi pass and the FIX state.
module cpu_0_mul_seq (
  input logic            clk,
  input logic            reset_n,
  cpu_0_mul_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StMul, StAcc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [1:0]  cnt_q, pcnt_q;
  logic [63:0] acc_q;
  logic [31:0] prod_q;
  logic [31:0] result_q;

  logic [1:0]  last_cnt;
  logic [31:0] a_half, b_half;
  logic [63:0] addend, acc_sum;
  logic [31:0] corr_a, corr_b, hi_fix;

`ifdef CPU_0_MUL_EARLY_OUT_EN
  assign last_cnt = (op_q == 2'b00) ? 2'd2 : 2'd3;
`else
  assign last_cnt = 2'd3;
`endif

  // cnt bit 0 selects the A half, bit 1 the B half.
  assign a_half = {16'b0, cnt_q[0] ? a_q[31:16] : a_q[15:0]};
  assign b_half = {16'b0, cnt_q[1] ? b_q[31:16] : b_q[15:0]};

  always_comb begin
    addend = {32'b0, prod_q};
    case (pcnt_q)
      2'd1, 2'd2: addend = {16'b0, prod_q, 16'b0};
      2'd3:       addend = {prod_q, 32'b0};
      default:    addend = {32'b0, prod_q};
    endcase
  end

  assign acc_sum = acc_q + addend;

  // Signed correction of the unsigned high word.
  assign corr_a = ((op_q == 2'b10 || op_q == 2'b11) && a_q[31]) ? b_q : 32'b0;
  assign corr_b = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'b0;
  assign hi_fix = acc_q[63:32] - corr_a - corr_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start_valid) state_d = StMul;
      StMul:  if (cnt_q == last_cnt) state_d = StAcc;
      StAcc: begin
`ifdef CPU_0_MUL_EARLY_OUT_EN
        state_d = (op_q == 2'b00) ? StDone : StFix;
`else
        state_d = StFix;
`endif
      end
      StFix:  state_d = StDone;
      StDone: if (bus.result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.start_ready  = (state_q == StIdle);
    bus.busy         = (state_q != StIdle);
    bus.result_valid = (state_q == StDone);
    bus.result       = result_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= 2'b00;
      a_q      <= 32'b0;
      b_q      <= 32'b0;
      cnt_q    <= 2'd0;
      pcnt_q   <= 2'd0;
      acc_q    <= 64'b0;
      prod_q   <= 32'b0;
      result_q <= 32'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_valid) begin
            op_q  <= bus.op;
            a_q   <= bus.src1;
            b_q   <= bus.src2;
            cnt_q <= 2'd0;
            acc_q <= 64'b0;
          end
        end
        StMul: begin
          prod_q <= a_half * b_half;
          pcnt_q <= cnt_q;
          cnt_q  <= cnt_q + 2'd1;
          // The product register is only valid from the second issue onward.
          if (cnt_q != 2'd0) acc_q <= acc_sum;
        end
        StAcc: begin
          acc_q <= acc_sum;
`ifdef CPU_0_MUL_EARLY_OUT_EN
          if (op_q == 2'b00) result_q <= acc_sum[31:0];
`endif
        end
        StFix: begin
          result_q <= (op_q == 2'b00) ? acc_q[31:0] : hi_fix;
        end
        StDone: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_0_mul_seq.sv
// Directed-vector and reference-model bench for cpu_0_mul_seq.
module tb_cpu_0_mul_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_0_mul_seq_if bus ();

  cpu_0_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef CPU_0_MUL_EARLY_OUT_EN
    return (o == 2'b00) ? 5 : 7;
`else
    return (o == 2'b00) ? 7 : 7;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ae, be, p;
    ae = o[1] ? {{32{a[31]}}, a} : {32'b0, a};
    be = (o == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ae * be;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op, wait for the result, hold it for 'stall' cycles, then consume it.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output logic [31:0] res, output int lat);
    logic [31:0] first;
    bit stable;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op = o;
    bus.src1 = a;
    bus.src2 = b;
    check("start_ready_idle", {31'b0, bus.start_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Operands must only be sampled at accept.
    bus.start_valid = 1'b0;
    bus.op = 2'($urandom);
    bus.src1 = $urandom;
    bus.src2 = $urandom;
    lat = 1;
    while (!bus.result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    if (!bus.result_valid) begin
      check("result_valid_timeout", 32'd0, 32'd1);
      return;
    end
    first = bus.result;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!bus.result_valid || bus.result !== first || bus.start_ready || !bus.busy)
        stable = 1'b0;
    end
    if (stall > 0) check("stall_stable", {31'b0, stable}, 32'd1);
    bus.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("start_ready_after", {31'b0, bus.start_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] res;
    int lat;

    vecs[0]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[10] = '{2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001};
    vecs[11] = '{2'b01, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001};
    vecs[12] = '{2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
    vecs[13] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};

    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    bus.op   = 2'b00;
    bus.src1 = 32'b0;
    bus.src2 = 32'b0;

    #12;
    check("rst_result_valid", {31'b0, bus.result_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_start_ready", {31'b0, bus.start_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op));
    end

    // Backpressure: ten stalled cycles in DONE.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, res, lat);
    check("bp_result", res, 32'hFFFF_FFFE);

    // Reset asserted mid-operation at T+3.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op = 2'b11;
    bus.src1 = 32'h8000_0000;
    bus.src2 = 32'h8000_0000;
    @(posedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_result_valid", {31'b0, bus.result_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_start_ready", {31'b0, bus.start_ready}, 32'd1);
    check("midrst_result", bus.result, 32'd0);
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 0, res, lat);
    check("postrst_result", res, 32'h4000_0000);

    // Random regression against the 64-bit reference model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = {a[31], 31'b0};
      run_op(o, a, b, $urandom_range(0, 3), res, lat);
      check($sformatf("rand%0d_op%0d_result", i, o), res, model(o, a, b));
      check($sformatf("rand%0d_latency", i), lat, exp_lat(o));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
